// File: rtl/viterbi_pkg.sv
// Shared convolutional-code definitions: default code parameters, encoder FSM
// states and a parity helper used by the encoder and the decoder blocks.
package viterbi_pkg;

  localparam int K_DEF = 3;
  localparam int M_DEF = K_DEF - 1;
  localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
  localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

  // Widest tap window the parity helper accepts; callers zero-extend.
  localparam int PAR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_fsm_e;

  function automatic logic parity(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/stream_reg.sv
// Single-entry valid/ready output register: loads when empty or when the
// downstream consumes, and holds its data stable while stalled.
module stream_reg #(
  parameter int DATA_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with a registered valid/ready
// output. Define CONV_ENCODER_TAIL_EN to append M zero tail bits per frame.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int             K  = K_DEF,
  parameter logic [K-1:0]   G0 = K'(G0_DEF),
  parameter logic [K-1:0]   G1 = K'(G1_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_sym,
  output logic         out_last,
  output logic [K-2:0] enc_state
);

  localparam int M = K - 1;

  enc_fsm_e     state_q;
  logic [M-1:0] shreg_q, shreg_d;
  logic         load_ok, accept, produce, bit_enc, sym_last;
  logic [K-1:0] win;
  logic [2:0]   sr_data, sr_out;

  assign in_ready = !rst && load_ok && (state_q != ST_TAIL);
  assign accept   = in_valid && in_ready;

`ifdef CONV_ENCODER_TAIL_EN
  localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
  logic [CNT_W-1:0] tail_cnt_q;
  logic             tail_step, tail_done;

  // Tail bits are zeros, one per output-register load, no upstream handshake.
  assign tail_step = !rst && load_ok && (state_q == ST_TAIL);
  assign tail_done = tail_step && (tail_cnt_q == CNT_W'(M - 1));
  assign produce   = accept || tail_step;
  assign bit_enc   = tail_step ? 1'b0 : in_bit;
  assign sym_last  = tail_done;
`else
  assign produce   = accept;
  assign bit_enc   = in_bit;
  assign sym_last  = accept && in_last;
`endif

  assign win     = {bit_enc, shreg_q};
  assign sr_data = {parity(PAR_W'(win & G0)), parity(PAR_W'(win & G1)), sym_last};

  always_comb begin
    shreg_d = shreg_q;
    // New bit enters at the MSB; the window shifted right by one is the next state.
    if (produce) shreg_d = M'({bit_enc, shreg_q} >> 1);
`ifndef CONV_ENCODER_TAIL_EN
    if (accept && in_last) shreg_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
`ifdef CONV_ENCODER_TAIL_EN
      tail_cnt_q <= '0;
`endif
    end else begin
      shreg_q <= shreg_d;
      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (accept) begin
`ifdef CONV_ENCODER_TAIL_EN
            state_q <= in_last ? ST_TAIL : ST_DATA;
`else
            state_q <= in_last ? ST_IDLE : ST_DATA;
`endif
          end
        end
`ifdef CONV_ENCODER_TAIL_EN
        ST_TAIL: begin
          if (tail_done) begin
            state_q    <= ST_IDLE;
            tail_cnt_q <= '0;
          end else if (tail_step) begin
            tail_cnt_q <= tail_cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stream_reg #(.DATA_W(3)) u_out_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (produce),
    .ready_o (load_ok),
    .data_i  (sr_data),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (sr_out)
  );

  assign out_sym   = sr_out[2:1];
  assign out_last  = sr_out[0];
  assign enc_state = shreg_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder (default K=3, G0=7, G1=5); follows the
// CONV_ENCODER_TAIL_EN define of the build.
module tb_conv_encoder;

  localparam int K = 3;
  localparam int M = K - 1;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_bit, in_last;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, out_last;
  logic [1:0]   out_sym;
  logic [M-1:0] enc_state;

  int           n_cmp = 0, n_err = 0;
  int           mode = 0;
  int           cyc = 0;
  logic [4:0]   exp_q[$];   // {sym, last, state after encode}
  logic [4:0]   obs_q[$];
  int           obs_cyc[$];
  logic [M-1:0] m_state = '0;

  conv_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_last  (out_last),
    .enc_state (enc_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sym(input logic b, input logic [M-1:0] s);
    logic [K-1:0] w;
    w = {b, s};
    return {^(w & G0), ^(w & G1)};
  endfunction

  task automatic model_accept(input logic b, input logic last);
    logic [1:0] sym;
    sym     = ref_sym(b, m_state);
    m_state = {b, m_state[M-1:1]};
`ifdef CONV_ENCODER_TAIL_EN
    exp_q.push_back({sym, 1'b0, m_state});
    if (last) begin
      for (int t = 0; t < M; t++) begin
        sym     = ref_sym(1'b0, m_state);
        m_state = {1'b0, m_state[M-1:1]};
        exp_q.push_back({sym, (t == M - 1), m_state});
      end
    end
`else
    if (last) m_state = '0;
    exp_q.push_back({sym, last, m_state});
`endif
  endtask

  task automatic send_bit(input logic b, input logic last);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    for (int w = 0; w < 200; w++) begin
      #1;
      acc = in_ready;
      if (acc) model_accept(b, last);
      @(posedge clk);
      #1;
      if (acc) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check_eq("accept_timeout", acc, 1'b1);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int len);
    for (int i = 0; i < len; i++) send_bit(bits[i], i == len - 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    check_eq("end_state", enc_state, 0);
  endtask

  task automatic check_1011(input string tag);
    logic [4:0] t[6];
    int         n;
`ifdef CONV_ENCODER_TAIL_EN
    t = '{5'b11010, 5'b10001, 5'b00010, 5'b01011, 5'b01001, 5'b11100};
    n = 6;
`else
    t = '{5'b11010, 5'b10001, 5'b00010, 5'b01100, 5'b00000, 5'b00000};
    n = 4;
`endif
    check_eq({tag, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) check_eq(tag, obs_q[i], t[i]);
  endtask

  // Output side: drive out_ready per mode, check stall behaviour, pop scoreboard.
  initial begin
    logic [2:0] held;
    bit         held_v;
    int         pat;
    held_v = 0;
    pat    = 0;
    held   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1: begin out_ready = (pat == 0 || pat == 3); pat = (pat + 1) % 4; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (held_v) check_eq("hold", {out_valid, out_sym, out_last}, {1'b1, held});
      held_v = 0;
      if (out_valid && !out_ready) begin
        held   = {out_sym, out_last};
        held_v = 1;
        check_eq("ready_stall", in_ready, 1'b0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_sym", exp_q.size(), 1);
        end else begin
          check_eq("sym", {out_sym, out_last, enc_state}, exp_q.pop_front());
        end
        obs_q.push_back({out_sym, out_last, enc_state});
        obs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [47:0]  rf;
    logic [47:0]  dec;
    logic [M-1:0] s;
    logic         b;
    int           bad;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_sym", {out_sym, out_last}, 3'b000);
    check_eq("rst_enc_state", enc_state, 0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Frame 1,0,1,1 at full rate
    mode = 0;
    obs_q.delete(); obs_cyc.delete();
    send_frame(64'b1101, 4);
    drain();
    check_1011("f1011_full");
    check_eq("f1011_full_span", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], obs_cyc.size() - 1);

    // Same frame under 1,0,0,1 back-pressure
    mode = 1;
    obs_q.delete(); obs_cyc.delete();
    send_frame(64'b1101, 4);
    drain();
    check_1011("f1011_stall");

    // Back-to-back single-bit frames
    mode = 0;
    obs_q.delete(); obs_cyc.delete();
    send_frame(64'b1, 1);
    send_frame(64'b1, 1);
    drain();
`ifdef CONV_ENCODER_TAIL_EN
    check_eq("b2b_count", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      check_eq("b2b_seq", {obs_q[0], obs_q[1], obs_q[2]}, {5'b11010, 5'b10001, 5'b11100});
      check_eq("b2b_seq2", {obs_q[3], obs_q[4], obs_q[5]}, {5'b11010, 5'b10001, 5'b11100});
    end
`else
    check_eq("b2b_count", obs_q.size(), 2);
    if (obs_q.size() == 2) check_eq("b2b_seq", {obs_q[0], obs_q[1]}, {5'b11100, 5'b11100});
`endif
    if (obs_cyc.size() > 0)
      check_eq("b2b_span", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], obs_cyc.size() - 1);

    // Reset after two bits of a frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    exp_q.delete();
    m_state = '0;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_enc_state", enc_state, 0);
    check_eq("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_ready_after", in_ready, 1'b1);
    obs_q.delete(); obs_cyc.delete();
    send_frame(64'b1101, 4);
    drain();
    check_1011("f1011_after_rst");

    // Random 48-bit frame under random back-pressure, hard-decision decode
    mode = 2;
    obs_q.delete(); obs_cyc.delete();
    rf = {$urandom(), $urandom()};
    send_frame({16'h0, rf}, 48);
    drain();
`ifdef CONV_ENCODER_TAIL_EN
    check_eq("rand_count", obs_q.size(), 48 + M);
`else
    check_eq("rand_count", obs_q.size(), 48);
`endif
    s   = '0;
    dec = '0;
    bad = 0;
    for (int i = 0; i < 48 && i < obs_q.size(); i++) begin
      b = obs_q[i][3] ^ s[0];
      if (obs_q[i][4] != (b ^ s[1] ^ s[0])) bad++;
      dec[i] = b;
      s = {b, s[1]};
    end
    check_eq("rand_decode", dec, rf);
    check_eq("rand_g0_consistency", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
- REQ-001 Parameter K, default 3: constraint length; M = K-1 memory bits.
- REQ-002 Parameter G0, default 3'b111 (octal 7): first generator polynomial, K bits.
- REQ-003 Parameter G1, default 3'b101 (octal 5): second generator polynomial, K bits.
- REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005 rst  input  1  reset; synchronous, active-high.
- REQ-006 in_valid  input  1  in_bit/in_last are valid.
- REQ-007 in_ready  output  1  encoder accepts input this cycle.
- REQ-008 in_bit  input  1  information bit.
- REQ-009 in_last  input  1  marks the final information bit of a frame.
- REQ-010 out_valid  output  1  out_sym/out_last are valid.
- REQ-011 out_ready  input  1  downstream accepts a symbol this cycle.
- REQ-012 out_sym  output  2  coded symbol {g0_bit, g1_bit}.
- REQ-013 out_last  output  1  marks the final symbol of a frame.
- REQ-014 enc_state  output  M  current shift-register state, for bench and decoder cross-checking.

Function
- REQ-015 The K-bit window SHALL be w = {b, enc_state}, where b is the bit being encoded; g0_bit = XOR-reduce(w & G0); g1_bit = XOR-reduce(w & G1).
- REQ-016 On encode, the next state SHALL be {b, enc_state[M-1:1]}: new bit into the MSB, right shift. This matches the traceback state convention.
- REQ-017 FSM states SHALL be IDLE, DATA and TAIL. IDLE->DATA on the first accepted input. DATA->TAIL on an accepted in_last (tail build only). TAIL->IDLE after M tail bits. DATA->IDLE on in_last when tail is excluded.
- REQ-018 in_ready SHALL be (!out_valid || out_ready) && state != TAIL; an input transfer occurs when in_valid && in_ready.
- REQ-019 An accepted bit SHALL appear on out_sym with out_valid=1 on the following cycle (1-cycle latency). The output register loads whenever it is empty or out_ready=1.
- REQ-020 out_sym and out_last SHALL hold stable while out_valid && !out_ready.
- REQ-021 In TAIL, the block SHALL encode b=0 once per output-register load. A tail counter SHALL count 0..M-1. The final tail symbol SHALL carry out_last=1.
- REQ-022 Full throughput SHALL be one symbol per cycle with out_ready held at 1, including back-to-back frames with no idle cycle.
- REQ-023 enc_state SHALL be 0 at every frame start.
- REQ-024 An in_valid that is low mid-frame SHALL stall without changing enc_state.
- REQ-025 A single-bit frame (in_last on the first bit) SHALL be legal.

Reset
- REQ-026 While rst=1, the block SHALL set FSM=IDLE, enc_state=0, tail counter=0, out_valid=0, out_sym=0, out_last=0 and in_ready=0.
- REQ-027 Reset mid-frame SHALL discard the frame and any pending output symbol; the block SHALL emit no tail.
- REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
- REQ-029 Macro CONV_ENCODER_TAIL_EN SHALL control frame termination.
- REQ-030 With CONV_ENCODER_TAIL_EN defined, the block SHALL append M zero tail bits, out_last SHALL mark the last tail symbol, and the frame SHALL end in state 0 naturally.
- REQ-031 Without CONV_ENCODER_TAIL_EN, the TAIL state and tail counter SHALL not be built. out_last SHALL mark the symbol of the in_last bit, and enc_state SHALL be forced to 0 after that symbol.

Structure
- REQ-032 Package viterbi_pkg SHALL hold K, M, G0, G1 defaults, the FSM state enum type and a parity function; the decoder blocks SHALL share it.
- REQ-033 The output register with its valid/ready hold logic SHALL be one sub-module, stream_reg, parameterized by width (3 bits: sym + last).

Verification
- REQ-034 Frame 1,0,1,1 (in_last on the final bit), tail on, out_ready=1 -> out_sym 11,10,00,01,01,11, out_last only on the 6th symbol, enc_state 10,01,10,11,01,00.
- REQ-035 Same frame, tail off -> out_sym 11,10,00,01 with out_last on the 4th, then enc_state=0.
- REQ-036 Frame 1,0,1,1 with out_ready toggling 1,0,0,1,... -> identical symbol sequence, no drops or duplicates, out_sym stable while stalled, in_ready=0 while the output is full and not ready.
- REQ-037 Two back-to-back frames "1" and "1", tail on -> symbols 11,10,11 then 11,10,11, second frame starting from state 0 with no idle cycle.
- REQ-038 rst asserted after 2 bits of a frame -> next cycle out_valid=0, enc_state=0; a new frame encodes as from power-up.
- REQ-039 Random 48-bit frame fed to a reference model and then to the viterbi decoder chain -> all symbols match the model, and the decoded bits equal the input.
